// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor resolve path.
package bp_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred;
    } br_entry_t;

    typedef enum logic {
        BR_IDLE  = 1'b0,
        BR_FLUSH = 1'b1
    } br_state_t;

    // Sequential fall-through PC, wraps mod 2^PC_W.
    function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
        return PC_W'(pc + PC_W'(INSTR_BYTES));
    endfunction

endpackage

// File: rtl/br_track_fifo.sv
// In-flight branch tracker: DEPTH-entry FIFO of {pc, pred} with synchronous clear.
// Push while full is accepted only if a pop happens in the same cycle.
module br_track_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  br_entry_t              push_data,
    input  logic                   pop,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output br_entry_t              head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    br_entry_t        mem_q [DEPTH];
    br_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_int;
    logic             push_acc;
    logic             pop_acc;

    assign full_int = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head     = mem_q[rd_ptr_q];
    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full_int || pop_acc);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_acc && !pop_acc) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_acc && !push_acc) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolve side of the 2-bit branch predictor: tracks predictions, updates the predictor,
// flushes and redirects on mispredict. BRANCH_STATS_EN adds resolution/mispredict counters.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            br_push,
    input  logic [PC_W-1:0] br_pc,
    input  logic            br_pred,
    output logic            full,
    input  logic            ex_valid,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    output logic            upd_valid,
    output logic            upd_actual,
    output logic [PC_W-1:0] upd_pc,
    output logic            flush,
    output logic [PC_W-1:0] redirect_pc,
    output logic            err_underflow
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned FC_W  = $clog2(FLUSH_CYCLES + 1);

    br_state_t       state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;

    logic [CNT_W-1:0] trk_count;
    logic             trk_empty;
    br_entry_t        trk_head;
    br_entry_t        push_entry;

    logic in_idle, resolve, mispred, underflow;

    logic            upd_valid_q, upd_valid_d;
    logic            upd_actual_q, upd_actual_d;
    logic [PC_W-1:0] upd_pc_q, upd_pc_d;
    logic            flush_q, flush_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
    logic            err_q, err_d;

    assign in_idle    = (state_q == BR_IDLE);
    assign resolve    = in_idle && ex_valid && !trk_empty;
    assign underflow  = in_idle && ex_valid && trk_empty;
    assign mispred    = resolve && (trk_head.pred != ex_taken);
    assign push_entry = '{pc: br_pc, pred: br_pred};
    assign full       = (trk_count == CNT_W'(DEPTH));

    // Mispredict clears younger wrong-path entries, overriding any same-cycle push.
    br_track_fifo #(.DEPTH(DEPTH)) u_track (
        .clk       (clk),
        .reset     (reset),
        .push      (in_idle && br_push),
        .push_data (push_entry),
        .pop       (resolve),
        .clear     (mispred),
        .count     (trk_count),
        .empty     (trk_empty),
        .head      (trk_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BR_IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Flush window length set by a down-counter loaded on mispredict.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            BR_IDLE: begin
                if (mispred) begin
                    state_d = BR_FLUSH;
                    fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            BR_FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = BR_IDLE;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            default: state_d = BR_IDLE;
        endcase
    end

    always_comb begin
        upd_valid_d   = resolve;
        upd_actual_d  = upd_actual_q;
        upd_pc_d      = upd_pc_q;
        flush_d       = (state_d == BR_FLUSH);
        redirect_pc_d = redirect_pc_q;
        err_d         = err_q | underflow;
        if (resolve) begin
            upd_actual_d = ex_taken;
            upd_pc_d     = trk_head.pc;
        end
        if (mispred) begin
            redirect_pc_d = ex_taken ? ex_target : next_seq_pc(trk_head.pc);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_valid_q   <= 1'b0;
            upd_actual_q  <= 1'b0;
            upd_pc_q      <= '0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            err_q         <= 1'b0;
        end else begin
            upd_valid_q   <= upd_valid_d;
            upd_actual_q  <= upd_actual_d;
            upd_pc_q      <= upd_pc_d;
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
            err_q         <= err_d;
        end
    end

    assign upd_valid     = upd_valid_q;
    assign upd_actual    = upd_actual_q;
    assign upd_pc        = upd_pc_q;
    assign flush         = flush_q;
    assign redirect_pc   = redirect_pc_q;
    assign err_underflow = err_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    // Saturating event counters.
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (resolve && (stat_branches_q != 32'hFFFF_FFFF)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (mispred && (stat_mispred_q != 32'hFFFF_FFFF)) begin
            stat_mispred_d = stat_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit; predictor updates checked through a scoreboard.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br_push = 1'b0;
    logic [31:0] br_pc = '0;
    logic        br_pred = 1'b0;
    logic        full;
    logic        ex_valid = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        upd_valid;
    logic        upd_actual;
    logic [31:0] upd_pc;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        err_underflow;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        actual;
        logic [31:0] pc;
    } upd_exp_t;

    upd_exp_t exp_q[$];
    upd_exp_t mon_e;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .br_push       (br_push),
        .br_pc         (br_pc),
        .br_pred       (br_pred),
        .full          (full),
        .ex_valid      (ex_valid),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .upd_valid     (upd_valid),
        .upd_actual    (upd_actual),
        .upd_pc        (upd_pc),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .err_underflow (err_underflow)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
`endif
    );

    // Scoreboard: every update pulse must match the oldest expected resolution.
    always @(posedge clk) begin
        #1;
        if (!reset && upd_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL upd_unexpected: got pc=%h actual=%b, no update expected", upd_pc, upd_actual);
            end else begin
                mon_e = exp_q.pop_front();
                if (upd_actual !== mon_e.actual || upd_pc !== mon_e.pc) begin
                    fails++;
                    $display("FAIL upd_payload: got actual=%b pc=%h, want actual=%b pc=%h",
                             upd_actual, upd_pc, mon_e.actual, mon_e.pc);
                end
            end
        end
    end

    // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
    task automatic cyc(input logic p, input logic [31:0] pc, input logic pr,
                       input logic ev, input logic tk, input logic [31:0] tg);
        @(negedge clk);
        br_push   = p;
        br_pc     = pc;
        br_pred   = pr;
        ex_valid  = ev;
        ex_taken  = tk;
        ex_target = tg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        br_push = 1'b0; br_pc = '0; br_pred = 1'b0;
        ex_valid = 1'b0; ex_taken = 1'b0; ex_target = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #12;
        tests++;
        if ({full, upd_valid, upd_actual, flush, err_underflow} !== 5'b0 ||
            upd_pc !== 32'h0 || redirect_pc !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: got full=%b upd_valid=%b flush=%b err=%b upd_pc=%h redirect=%h, want all 0",
                     full, upd_valid, flush, err_underflow, upd_pc, redirect_pc);
        end
`ifdef BRANCH_STATS_EN
        tests++;
        if (stat_branches !== 32'h0 || stat_mispred !== 32'h0) begin
            fails++;
            $display("FAIL reset_stats: got %0d/%0d, want 0/0", stat_branches, stat_mispred);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_hit();
        cyc(1, 32'h100, 1, 0, 0, 0);
        exp_q.push_back('{actual: 1'b1, pc: 32'h100});
        cyc(0, 0, 0, 1, 1, 32'h5000);
        tests++;
        if (upd_valid !== 1'b1 || flush !== 1'b0) begin
            fails++;
            $display("FAIL hit_update: got upd_valid=%b flush=%b, want 1/0", upd_valid, flush);
        end
        cyc(0, 0, 0, 0, 0, 0);
        tests++;
        if (upd_valid !== 1'b0) begin
            fails++;
            $display("FAIL hit_pulse: got upd_valid=%b on second cycle, want 0", upd_valid);
        end
    endtask

    task automatic test_mispred_taken();
        cyc(1, 32'h200, 0, 0, 0, 0);
        exp_q.push_back('{actual: 1'b1, pc: 32'h200});
        cyc(1, 32'h999, 1, 1, 1, 32'h400);
        tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h400 || upd_valid !== 1'b1) begin
            fails++;
            $display("FAIL mp_taken: got flush=%b redirect=%h upd_valid=%b, want 1/00000400/1",
                     flush, redirect_pc, upd_valid);
        end
        cyc(1, 32'h500, 1, 0, 0, 0);
        tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h400) begin
            fails++;
            $display("FAIL mp_flush2: got flush=%b redirect=%h, want 1/00000400", flush, redirect_pc);
        end
        cyc(0, 0, 0, 1, 1, 32'h700);
        tests++;
        if (flush !== 1'b0 || upd_valid !== 1'b0 || err_underflow !== 1'b0) begin
            fails++;
            $display("FAIL mp_flush_end: got flush=%b upd_valid=%b err=%b, want 0/0/0",
                     flush, upd_valid, err_underflow);
        end
        // Tracker must hold only the new branch, not any flushed push.
        cyc(1, 32'h600, 1, 0, 0, 0);
        exp_q.push_back('{actual: 1'b1, pc: 32'h600});
        cyc(0, 0, 0, 1, 1, 0);
        tests++;
        if (upd_valid !== 1'b1 || flush !== 1'b0) begin
            fails++;
            $display("FAIL mp_after: got upd_valid=%b flush=%b, want 1/0", upd_valid, flush);
        end
    endtask

    task automatic test_mispred_not_taken();
        cyc(1, 32'h300, 1, 0, 0, 0);
        exp_q.push_back('{actual: 1'b0, pc: 32'h300});
        cyc(0, 0, 0, 1, 0, 32'hDEAD_0000);
        tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h304) begin
            fails++;
            $display("FAIL mp_nt: got flush=%b redirect=%h, want 1/00000304", flush, redirect_pc);
        end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 32'hFFFF_FFFC, 1, 0, 0, 0);
        exp_q.push_back('{actual: 1'b0, pc: 32'hFFFF_FFFC});
        cyc(0, 0, 0, 1, 0, 32'h1234);
        tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h0) begin
            fails++;
            $display("FAIL mp_wrap: got flush=%b redirect=%h, want 1/00000000", flush, redirect_pc);
        end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_full_order();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'h1000 + 32'(i * 16), 1, 0, 0, 0);
            tests++;
            if (full !== (i == 3)) begin
                fails++;
                $display("FAIL full_fill%0d: got full=%b, want %b", i, full, (i == 3));
            end
        end
        cyc(1, 32'h2000, 1, 0, 0, 0);
        tests++;
        if (full !== 1'b1) begin
            fails++;
            $display("FAIL full_drop: got full=%b, want 1", full);
        end
        exp_q.push_back('{actual: 1'b1, pc: 32'h1000});
        cyc(1, 32'h1040, 1, 1, 1, 0);
        tests++;
        if (full !== 1'b1 || flush !== 1'b0) begin
            fails++;
            $display("FAIL full_pushpop: got full=%b flush=%b, want 1/0", full, flush);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{actual: 1'b1, pc: 32'h1010 + 32'(i * 16)});
            cyc(0, 0, 0, 1, 1, 0);
            tests++;
            if (full !== 1'b0 || flush !== 1'b0) begin
                fails++;
                $display("FAIL full_drain%0d: got full=%b flush=%b, want 0/0", i, full, flush);
            end
        end
    endtask

    task automatic test_underflow();
        cyc(0, 0, 0, 1, 1, 32'h40);
        tests++;
        if (upd_valid !== 1'b0 || flush !== 1'b0 || err_underflow !== 1'b1) begin
            fails++;
            $display("FAIL underflow: got upd_valid=%b flush=%b err=%b, want 0/0/1",
                     upd_valid, flush, err_underflow);
        end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        tests++;
        if (err_underflow !== 1'b1) begin
            fails++;
            $display("FAIL underflow_sticky: got err=%b, want 1", err_underflow);
        end
    endtask

    task automatic test_reset_mid_flush();
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h700 + 32'(i * 4), 0, 0, 0, 0);
        end
        exp_q.push_back('{actual: 1'b1, pc: 32'h700});
        cyc(0, 0, 0, 1, 1, 32'h800);
        tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h800) begin
            fails++;
            $display("FAIL rmf_setup: got flush=%b redirect=%h, want 1/00000800", flush, redirect_pc);
        end
        #2;
        idle_inputs();
        reset = 1'b1;
        #1;
        tests++;
        if (flush !== 1'b0 || full !== 1'b0 || upd_valid !== 1'b0 || err_underflow !== 1'b0) begin
            fails++;
            $display("FAIL rmf_async: got flush=%b full=%b upd_valid=%b err=%b, want 0/0/0/0",
                     flush, full, upd_valid, err_underflow);
        end
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 32'h900, 0, 0, 0, 0);
        exp_q.push_back('{actual: 1'b0, pc: 32'h900});
        cyc(0, 0, 0, 1, 0, 0);
        tests++;
        if (upd_valid !== 1'b1 || flush !== 1'b0) begin
            fails++;
            $display("FAIL rmf_idle: got upd_valid=%b flush=%b, want 1/0", upd_valid, flush);
        end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        test_reset();
        cyc(1, 32'hA00, 1, 0, 0, 0);
        cyc(1, 32'hA04, 0, 0, 0, 0);
        cyc(1, 32'hA08, 1, 0, 0, 0);
        exp_q.push_back('{actual: 1'b1, pc: 32'hA00});
        cyc(0, 0, 0, 1, 1, 0);
        exp_q.push_back('{actual: 1'b0, pc: 32'hA04});
        cyc(0, 0, 0, 1, 0, 0);
        exp_q.push_back('{actual: 1'b0, pc: 32'hA08});
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        tests++;
        if (stat_branches !== 32'd3 || stat_mispred !== 32'd1) begin
            fails++;
            $display("FAIL stats_count: got %0d/%0d, want 3/1", stat_branches, stat_mispred);
        end
        idle_inputs();
        reset = 1'b1;
        #1;
        tests++;
        if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
            fails++;
            $display("FAIL stats_reset: got %0d/%0d, want 0/0", stat_branches, stat_mispred);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_hit();
        test_mispred_taken();
        test_mispred_not_taken();
        test_full_order();
        test_underflow();
        test_reset_mid_flush();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        cyc(0, 0, 0, 0, 0, 0);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expected updates never seen, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
